// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types, including the fetch-queue entry.
package rv32i_types;
   typedef logic [31:0] rv32i_word;
   typedef struct packed {
      rv32i_word pc;
      rv32i_word ir;
   } fq_entry_t;
   typedef struct packed {
      logic      valid;
      rv32i_word pc;
      rv32i_word ir;
   } IF_ID_stage_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode FIFO with valid/ready handshakes and flush.
module fetch_queue
   import rv32i_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [31:0]              push_pc,
   input  logic [31:0]              push_ir,
   output logic                     push_ready,
   output logic                     pop_valid,
   output logic [31:0]              pop_pc,
   output logic [31:0]              pop_ir,
   input  logic                     pop_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   fq_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
   logic empty, full, push_fire, pop_fire;
   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty      = rd_ptr_q == wr_ptr_q;
   assign full       = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
   assign push_ready = !full && !rst;
   assign pop_valid  = !empty;
   assign pop_pc     = mem_q[rd_ptr_q[AW-1:0]].pc;
   assign pop_ir     = mem_q[rd_ptr_q[AW-1:0]].ir;
   assign count      = count_q;
   assign push_fire  = push_valid && push_ready && !flush;
   assign pop_fire   = pop_valid && pop_ready && !flush;
   always_comb begin
      mem_d = mem_q;
      if (push_fire) mem_d[wr_ptr_q[AW-1:0]] = '{pc: push_pc, ir: push_ir};
      wr_ptr_d = flush ? '0 : wr_ptr_q + (AW+1)'(push_fire);
      rd_ptr_d = flush ? '0 : rd_ptr_q + (AW+1)'(pop_fire);
      count_d  = flush ? '0 : count_q + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
   // Storage is never cleared; entries are invalidated only through the pointers.
   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue and decoupled pop monitor.
module tb_fetch_queue;
   import rv32i_types::*;
   logic        clk = 0, rst = 1;
   logic        push_valid = 0, pop_ready = 0, flush = 0;
   logic [31:0] push_pc = 0, push_ir = 0;
   logic        push_ready, pop_valid;
   logic [31:0] pop_pc, pop_ir;
   logic [2:0]  count;
   int          vecs = 0, errs = 0, m_cnt = 0;
   fq_entry_t   sb[$];

   fetch_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .push_valid(push_valid), .push_pc(push_pc), .push_ir(push_ir),
      .push_ready(push_ready), .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_ir(pop_ir),
      .pop_ready(pop_ready), .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT hands an entry to decode.
   always @(negedge clk) begin
      if (!rst && pop_valid === 1'b1 && pop_ready === 1'b1) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL pop_extra: got pc %h expected no entry", pop_pc);
         end else begin
            fq_entry_t e;
            e = sb.pop_front();
            chk("pop_pc", pop_pc, e.pc);
            chk("pop_ir", pop_ir, e.ir);
         end
      end
   end

   // One cycle: drive, check status against the model at negedge, update model at posedge.
   task automatic cyc(input logic pv, input logic [31:0] pc, input logic [31:0] ir,
                      input logic pr, input logic fl, output logic acc);
      logic pop;
      push_valid = pv; push_pc = pc; push_ir = ir; pop_ready = pr; flush = fl;
      @(negedge clk);
      chk("push_ready", {31'b0, push_ready}, {31'b0, m_cnt < 4});
      chk("pop_valid",  {31'b0, pop_valid},  {31'b0, m_cnt > 0});
      chk("count",      {29'b0, count},      32'(m_cnt));
      @(posedge clk);
      acc = pv && m_cnt < 4 && !fl;
      pop = pr && m_cnt > 0 && !fl;
      if (fl) begin
         sb.delete();
         m_cnt = 0;
      end else begin
         if (acc) sb.push_back('{pc: pc, ir: ir});
         m_cnt = m_cnt + int'(acc) - int'(pop);
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic a;
      logic [31:0] fill_pc [4] = '{32'h60, 32'h64, 32'h68, 32'h6C};
      logic [31:0] fill_ir [4] = '{32'h00100093, 32'h00200113, 32'h002081B3, 32'h00302023};
      int i, guard;
      rst = 1;
      @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         chk("rst_push_ready", {31'b0, push_ready}, 32'd0);
         chk("rst_pop_valid",  {31'b0, pop_valid},  32'd0);
         chk("rst_count",      {29'b0, count},      32'd0);
      end
      @(posedge clk);
      #1 rst = 0;
      for (int k = 0; k < 4; k++) cyc(1, fill_pc[k], fill_ir[k], 0, 0, a);
      cyc(1, 32'h70, 32'h00000073, 1, 0, a);
      chk("full_pop_push_rejected", {31'b0, a}, 32'd0);
      cyc(1, 32'h70, 32'h00000073, 0, 0, a);
      chk("repush_accepted", {31'b0, a}, 32'd1);
      repeat (4) cyc(0, 0, 0, 1, 0, a);
      cyc(0, 0, 0, 1, 0, a);
      for (int k = 0; k < 3; k++) cyc(1, 32'h100 + 32'(4*k), 32'h13 + 32'(k), 0, 0, a);
      cyc(1, 32'h1FC, 32'hDEADBEEF, 1, 1, a);
      cyc(1, 32'h200, 32'h0000006F, 0, 0, a);
      cyc(0, 0, 0, 1, 0, a);
      cyc(0, 0, 0, 0, 0, a);
      i = 0;
      guard = 0;
      while (i < 20 && guard < 100) begin
         cyc(1, 32'h1000 + 32'(4*i), 32'hA0000000 + 32'(i), guard[0] == 1'b0, 0, a);
         if (a) i++;
         guard++;
      end
      chk("stream_pushed", 32'(i), 32'd20);
      repeat (6) cyc(0, 0, 0, 1, 0, a);
      chk("stream_drained", 32'(sb.size()), 32'd0);
      cyc(1, 32'h80, 32'h00000013, 0, 0, a);
      cyc(0, 0, 0, 1, 0, a);
      cyc(0, 0, 0, 0, 0, a);
      chk("final_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
